// File: rtl/reg_write_buffer.sv
// Write-side driver for the register file write port.
// Buffers writeback results in a small FIFO, drains at most one per clock into registered
// writereg/writedata/RegWrite outputs, and exports a busy mask of registers with pending writes.
// Optional feature: define WB_COALESCE_EN to merge a write into the tail entry when it targets
// the same register.
`timescale 1ns/1ps
module reg_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AW-1:0]           in_reg,
  input  logic [DW-1:0]           in_data,
  input  logic                    wb_hold,
  output logic [AW-1:0]           writereg,
  output logic [DW-1:0]           writedata,
  output logic                    RegWrite,
  output logic [2**AW-1:0]        busy_mask,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [AW-1:0] reg_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] writereg_q;
  logic [DW-1:0] writedata_q;
  logic          regwrite_q;

  logic          pop, push, accept, not_full;
  logic [PW-1:0] offset;
  logic [2**AW-1:0] busy;

`ifdef WB_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  logic          coal_hit;
`endif

  // Handshake, push/pop decisions and next occupancy.
  always_comb begin
    pop      = (count_q != '0) && !wb_hold;
    not_full = (count_q < Full);
`ifdef WB_COALESCE_EN
    tail_ptr = wr_ptr_q - PW'(1);
    // A head entry leaving this edge cannot absorb the new write.
    coal_hit = (count_q != '0) && (in_reg != '0) && (reg_q[tail_ptr] == in_reg) &&
               !((count_q == CW'(1)) && pop);
    in_ready = not_full | coal_hit;
    accept   = in_valid & in_ready;
    push     = accept & (in_reg != '0) & !coal_hit;
`else
    in_ready = not_full;
    accept   = in_valid & in_ready;
    push     = accept & (in_reg != '0);
`endif
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage, pointers and the registered write-port stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      writereg_q  <= '0;
      writedata_q <= '0;
      regwrite_q  <= 1'b0;
    end else begin
      if (push) begin
        reg_q[wr_ptr_q]  <= in_reg;
        data_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
`ifdef WB_COALESCE_EN
      else if (accept && coal_hit) begin
        data_q[tail_ptr] <= in_data;
      end
`endif
      if (pop) begin
        writereg_q  <= reg_q[rd_ptr_q];
        writedata_q <= data_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + PW'(1);
      end
      regwrite_q <= pop;
      count_q    <= count_d;
    end
  end

  // Busy mask: every live FIFO entry plus the write currently presented to the register file.
  always_comb begin
    busy   = '0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        busy[reg_q[i]] = 1'b1;
      end
    end
    if (regwrite_q) begin
      busy[writereg_q] = 1'b1;
    end
  end

  assign busy_mask = busy;
  assign writereg  = writereg_q;
  assign writedata = writedata_q;
  assign RegWrite  = regwrite_q;
  assign count     = count_q;

endmodule
